// File: rtl/bit4_adder_if.sv
// -----------------------------------------------------------------------------
// bit4_adder_if
// Request/response bundle for the bit4_adder ALU slice.
//   in_valid  : operands and op are valid this cycle      (master -> slave)
//   op        : 00=ADD, 01=AND, 10=NOT(n1), 11=reserved   (master -> slave)
//   n1, n2    : operands A and B                          (master -> slave)
//   X         : registered result                         (slave -> master)
//   CCR       : registered flags {carry, overflow}        (slave -> master)
//   out_valid : X/CCR hold a result accepted last cycle   (slave -> master)
// -----------------------------------------------------------------------------
interface bit4_adder_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [1:0]       op;
  logic [WIDTH-1:0] n1;
  logic [WIDTH-1:0] n2;
  logic [WIDTH-1:0] X;
  logic [1:0]       CCR;
  logic             out_valid;

  modport master (
    output in_valid, op, n1, n2,
    input  X, CCR, out_valid
  );

  modport slave (
    input  in_valid, op, n1, n2,
    output X, CCR, out_valid
  );
endinterface

// File: rtl/bit4_adder.sv
// -----------------------------------------------------------------------------
// bit4_adder
// Registered WIDTH-bit arithmetic/logic slice (ADD, AND, NOT) used as a leaf of
// the team ALU. Operands are sampled on a rising clock edge when in_valid is
// high; result and condition codes appear one cycle later with out_valid.
//   clk    : single clock, rising-edge
//   rst_n  : asynchronous active-low reset (clears X, CCR, out_valid)
//   bus    : bit4_adder_if slave modport (in_valid/op/n1/n2 in,
//            X/CCR/out_valid out)
// -----------------------------------------------------------------------------
module bit4_adder #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  bit4_adder_if.slave  bus
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_AND = 2'b01,
    OP_NOT = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_overflow;
  logic [WIDTH-1:0] w_x;
  logic [1:0]       w_ccr;

  logic [WIDTH-1:0] r_x;
  logic [1:0]       r_ccr;
  logic             r_out_valid;

  // Ripple-carry chain of full-adder cells, carry-in tied to 0. The running
  // carry is a block-local variable so the chain stays a single combinational
  // path rather than a self-referencing vector.
  always_comb begin : ripple_add
    logic v_c;
    v_c   = 1'b0;
    w_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_sum[i] = bus.n1[i] ^ bus.n2[i] ^ v_c;
      v_c      = (bus.n1[i] & bus.n2[i]) | (v_c & (bus.n1[i] ^ bus.n2[i]));
    end
    w_carry = v_c;
  end

  // Signed overflow: operands share a sign but the sum's sign differs.
  assign w_overflow = (bus.n1[MSB] == bus.n2[MSB]) && (w_sum[MSB] != bus.n1[MSB]);

  // Result/flag select. Only ADD produces flags; every other op clears them.
  always_comb begin
    // NOTE: defaults first so every path assigns every output - no latches.
    w_x   = '0;
    w_ccr = 2'b00;
    case (op_e'(bus.op))
      OP_ADD: begin
        w_x   = w_sum;
        w_ccr = {w_carry, w_overflow};
      end
      OP_AND: w_x = bus.n1 & bus.n2;
      OP_NOT: w_x = ~bus.n1;
      default: ;  // reserved op: zero result, zero flags, still valid
    endcase
  end

  // Reset wins over a same-cycle request and discards any pending result.
  // NOTE: non-blocking assignments for all registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x         <= '0;
      r_ccr       <= 2'b00;
      r_out_valid <= 1'b0;
    end else if (bus.in_valid) begin
      r_x         <= w_x;
      r_ccr       <= w_ccr;
      r_out_valid <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;  // X/CCR hold while idle
    end
  end

  assign bus.X         = r_x;
  assign bus.CCR       = r_ccr;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_bit4_adder.sv
// -----------------------------------------------------------------------------
// tb_bit4_adder
// Directed, table-driven bench for bit4_adder: reset behaviour, each op with
// hand-computed results, back-to-back requests, idle hold, mid-cycle reset and
// an exhaustive ADD sweep against a small reference model.
// -----------------------------------------------------------------------------
module tb_bit4_adder;

  localparam int WIDTH = 4;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] n1;
    logic [3:0] n2;
    logic [3:0] x;
    logic [1:0] ccr;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  bit4_adder_if #(.WIDTH(WIDTH)) bus ();

  bit4_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one request at the falling edge, then sample 1 ns after the
  // accepting rising edge.
  task automatic issue(input logic [1:0] op, input logic [3:0] n1, input logic [3:0] n2);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.n1       = n1;
    bus.n2       = n2;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic [3:0] junk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op       = 2'b00;
    bus.n1       = junk;
    bus.n2       = ~junk;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [3:0] x,
                            input logic [1:0] ccr, input logic vld);
    check({name, ".X"},         {28'd0, bus.X},         {28'd0, x});
    check({name, ".CCR"},       {30'd0, bus.CCR},       {30'd0, ccr});
    check({name, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, vld});
  endtask

  vec_t vecs [8];

  initial begin
    n_checks = 0;
    n_errors = 0;

    vecs[0] = '{op: 2'b00, n1: 4'b0111, n2: 4'b0001, x: 4'b1000, ccr: 2'b01};
    vecs[1] = '{op: 2'b00, n1: 4'b1111, n2: 4'b0001, x: 4'b0000, ccr: 2'b10};
    vecs[2] = '{op: 2'b00, n1: 4'b1000, n2: 4'b1000, x: 4'b0000, ccr: 2'b11};
    vecs[3] = '{op: 2'b00, n1: 4'b0011, n2: 4'b0100, x: 4'b0111, ccr: 2'b00};
    vecs[4] = '{op: 2'b01, n1: 4'b1100, n2: 4'b1010, x: 4'b1000, ccr: 2'b00};
    vecs[5] = '{op: 2'b10, n1: 4'b0101, n2: 4'b1111, x: 4'b1010, ccr: 2'b00};
    vecs[6] = '{op: 2'b11, n1: 4'b1111, n2: 4'b1111, x: 4'b0000, ccr: 2'b00};
    vecs[7] = '{op: 2'b00, n1: 4'b1001, n2: 4'b1100, x: 4'b0101, ccr: 2'b11};

    // Reset held, with a request present: reset must win.
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.op       = 2'b00;
    bus.n1       = 4'b0011;
    bus.n2       = 4'b0100;
    #1;
    expect_out("reset_state", 4'b0000, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    expect_out("reset_wins", 4'b0000, 2'b00, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;

    // Single-op vectors.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].n1, vecs[i].n2);
      expect_out($sformatf("vec%0d", i), vecs[i].x, vecs[i].ccr, 1'b1);
    end

    // Back-to-back ADD, AND, NOT, then idle: results hold, out_valid drops.
    issue(2'b00, 4'b0111, 4'b0001);
    expect_out("b2b_add", 4'b1000, 2'b01, 1'b1);
    issue(2'b01, 4'b1100, 4'b1010);
    expect_out("b2b_and", 4'b1000, 2'b00, 1'b1);
    issue(2'b10, 4'b0101, 4'b1111);
    expect_out("b2b_not", 4'b1010, 2'b00, 1'b1);
    idle_cycle(4'b0110);
    expect_out("b2b_idle", 4'b1010, 2'b00, 1'b0);

    // Flags hold (not cleared) while idle, then are fully overwritten.
    issue(2'b00, 4'b1000, 4'b1000);
    expect_out("hold_add", 4'b0000, 2'b11, 1'b1);
    idle_cycle(4'b1111);
    expect_out("hold_idle1", 4'b0000, 2'b11, 1'b0);
    idle_cycle(4'b0001);
    expect_out("hold_idle2", 4'b0000, 2'b11, 1'b0);
    issue(2'b01, 4'b1111, 4'b0110);
    expect_out("overwrite_and", 4'b0110, 2'b00, 1'b1);

    // Mid-cycle asynchronous reset with a nonzero pending result.
    issue(2'b00, 4'b0111, 4'b0001);
    expect_out("pre_reset", 4'b1000, 2'b01, 1'b1);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 4'b0000, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive ADD sweep against a reference model.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [4:0] s;
        logic [3:0] av, bv;
        logic [1:0] eccr;
        av   = 4'(a);
        bv   = 4'(b);
        s    = {1'b0, av} + {1'b0, bv};
        eccr = {s[4], (av[3] == bv[3]) && (s[3] != av[3])};
        issue(2'b00, av, bv);
        check($sformatf("sweep_%0d_%0d", a, b),
              {25'd0, bus.out_valid, bus.X, bus.CCR},
              {25'd0, 1'b1, s[3:0], eccr});
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
